// File: rtl/conv3x3_stream_writer.sv
// conv3x3_stream_writer: applies a fixed 3x3 kernel to streamed RGB windows and writes one pixel per window to the frame BRAM
//   iClk, iRst_n        clock, asynchronous active-low reset
//   iStart, iMode       arm a frame (IDLE only); kernel 0 bypass, 1 gauss, 2 sharpen, 3 edge
//   i_valid, i_data     one 3x3 window per high cycle, pRC at [PIX_W*(3R+C) +: PIX_W]
//   i_ready             registered level, high while the frame still needs windows
//   wr_en/addr/data     output BRAM write port, raster order
//   busy, frame_done    RUN or DRAIN; one-cycle pulse after the last write
//   ovf_err             sticky: a window arrived that could not be accepted
module conv3x3_stream_writer #(
    parameter int IMG_W  = 480,
    parameter int IMG_H  = 272,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 24
) (
    input  logic                 iClk,
    input  logic                 iRst_n,
    input  logic                 iStart,
    input  logic [1:0]           iMode,
    input  logic                 i_valid,
    input  logic [PIX_W*9-1:0]   i_data,
    output logic                 i_ready,
    output logic                 wr_en,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [PIX_W-1:0]     wr_data,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 ovf_err
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [ADDR_W:0] NPIX = (ADDR_W+1)'(IMG_W * IMG_H);

    state_t                state, state_nx;
    logic [ADDR_W:0]       cnt;
    logic [1:0]            mode;
    logic [PIX_W*9-1:0]    w1;
    logic signed [12:0]    s2 [3];
    logic [PIX_W-1:0]      r3;
    logic                  v1, v2, v3;
    logic                  start, acc, last;

    // Per-channel kernel sum; gauss keeps the rounded sum, shifted down in the clamp stage.
    function automatic logic signed [12:0] kern(input logic [1:0] m, input logic [PIX_W*9-1:0] w, input int c);
        logic signed [12:0] p [9];
        logic signed [12:0] gx, gy;
        for (int i = 0; i < 9; i++) p[i] = {5'd0, w[PIX_W*i + 8*c +: 8]};
        gx = p[2] + (p[5] <<< 1) + p[8] - p[0] - (p[3] <<< 1) - p[6];
        gy = p[6] + (p[7] <<< 1) + p[8] - p[0] - (p[1] <<< 1) - p[2];
        gx = gx[12] ? -gx : gx;
        gy = gy[12] ? -gy : gy;
        return m == 2'd0 ? p[4] :
               m == 2'd1 ? p[0] + (p[1] <<< 1) + p[2] + (p[3] <<< 1) + (p[4] <<< 2)
                           + (p[5] <<< 1) + p[6] + (p[7] <<< 1) + p[8] + 13'sd8 :
               m == 2'd2 ? (p[4] <<< 2) + p[4] - p[1] - p[3] - p[5] - p[7] :
                           gx + gy;
    endfunction

    function automatic logic [7:0] clamp(input logic [1:0] m, input logic signed [12:0] v);
        return m == 2'd1 ? v[11:4] : v[12] ? 8'd0 : |v[11:8] ? 8'hFF : v[7:0];
    endfunction

    assign start      = iStart && state == IDLE;
    assign acc        = i_valid && state == RUN && cnt < NPIX;
    assign last       = acc && cnt == NPIX - 1'b1;
    assign busy       = state == RUN || state == DRAIN;
    assign frame_done = state == DONE;

    always_comb begin
        state_nx = state;
        state_nx = state == IDLE  ? (iStart ? RUN : IDLE) :
                   state == RUN   ? (last ? DRAIN : RUN) :
                   state == DRAIN ? ((v1 || v2 || v3) ? DRAIN : DONE) :
                                    IDLE;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            mode    <= '0;
            i_ready <= 1'b0;
            ovf_err <= 1'b0;
            w1      <= '0;
            v1      <= 1'b0;
            v2      <= 1'b0;
            v3      <= 1'b0;
            r3      <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            for (int c = 0; c < 3; c++) s2[c] <= '0;
        end else begin
            state <= state_nx;
            if (start) begin
                mode    <= iMode;
                cnt     <= '0;
                ovf_err <= 1'b0;
                i_ready <= 1'b1;
                wr_addr <= '0;
            end else begin
                if (i_valid && !acc) ovf_err <= 1'b1;
                if (last) i_ready <= 1'b0;
                if (acc) cnt <= cnt + 1'b1;
                if (wr_en) wr_addr <= wr_addr + 1'b1;
            end
            v1 <= acc;
            if (acc) w1 <= i_data;
            v2 <= v1;
            for (int c = 0; c < 3; c++) s2[c] <= kern(mode, w1, c);
            v3 <= v2;
            r3 <= {clamp(mode, s2[2]), clamp(mode, s2[1]), clamp(mode, s2[0])};
            wr_en   <= v3;
            wr_data <= r3;
        end
    end
endmodule
